// File: rtl/timer_poller_if.sv
// -----------------------------------------------------------------------------
// timer_poller_if
// Peripheral bus between the timer poller (initiator) and the memory-mapped
// timer (target).
//   bus_addr   16  address driven by the initiator
//   bus_we      1  write strobe, one cycle per write
//   bus_wdata   8  write data
//   bus_rdata   8  read data from the target, combinational; bit0 = triggered
// Modports: master (initiator side), slave (target side).
// -----------------------------------------------------------------------------
interface timer_poller_if;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_addr,
        output bus_we,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_we,
        input  bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/timer_poller.sv
// -----------------------------------------------------------------------------
// timer_poller
// Bus initiator that owns the memory-mapped timer. On start it programs the
// 32-bit trigger period MSB first, clears the timer, then polls the triggered
// flag. Each trigger is acknowledged by clearing the timer and produces a
// one-cycle tick.
//
// Ports
//   clk         clock
//   rst         asynchronous, active-high reset
//   start       pulse: latch period and begin programming (ignored while busy)
//   stop        pulse: return to IDLE at the next poll (held pending)
//   period      trigger value P; 0 selects DEFAULT_PERIOD
//   bus         timer_poller_if.master (bus_addr/bus_we/bus_wdata/bus_rdata)
//   busy        high in every state except IDLE
//   tick        one-cycle pulse per acknowledged trigger
//   tick_count  acknowledged triggers since last start, wraps 0xFFFF -> 0
//   wdog_err    sticky: no trigger within P+WDOG_MARGIN poll cycles
//
// Build option: define TIMER_POLLER_WDOG_EN to include the poll watchdog;
// otherwise wdog_err is tied to 0.
//
// Timer addresses come from the ADDR_TMR_* macros when constants.v is read
// ahead of this file; the fallbacks below are used otherwise.
//
// state | meaning
// IDLE  | waiting for start, bus quiet
// WR3   | writing P[31:24] to TMR_3
// WR2   | writing P[23:16] to TMR_2
// WR1   | writing P[15:8]  to TMR_1
// WR0   | writing P[7:0]   to TMR_0
// CLR   | clearing the timer, tick_count reset
// POLL  | reading the triggered flag, honouring a pending stop
// ACK   | clearing the timer after a trigger, tick pulse
// -----------------------------------------------------------------------------
`ifndef ADDR_TMR_0
`define ADDR_TMR_0 16'h0010
`endif
`ifndef ADDR_TMR_1
`define ADDR_TMR_1 16'h0011
`endif
`ifndef ADDR_TMR_2
`define ADDR_TMR_2 16'h0012
`endif
`ifndef ADDR_TMR_3
`define ADDR_TMR_3 16'h0013
`endif
`ifndef ADDR_TMR_RST
`define ADDR_TMR_RST 16'h0014
`endif

module timer_poller #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'h004C4B40,
    parameter int unsigned WDOG_MARGIN    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [31:0]        period,
    timer_poller_if.master     bus,
    output logic               busy,
    output logic               tick,
    output logic [15:0]        tick_count,
    output logic               wdog_err
);

    localparam logic [15:0] A_TMR_0   = `ADDR_TMR_0;
    localparam logic [15:0] A_TMR_1   = `ADDR_TMR_1;
    localparam logic [15:0] A_TMR_2   = `ADDR_TMR_2;
    localparam logic [15:0] A_TMR_3   = `ADDR_TMR_3;
    localparam logic [15:0] A_TMR_RST = `ADDR_TMR_RST;

    typedef enum logic [2:0] {
        S_IDLE, S_WR3, S_WR2, S_WR1, S_WR0, S_CLR, S_POLL, S_ACK
    } state_t;

    state_t      state;
    logic [31:0] p_q;
    logic        stop_pend;
    logic [31:0] p_new;
    logic        trig_seen;
    logic        unused_rdata;

    assign p_new        = (period == 32'd0) ? DEFAULT_PERIOD : period;
    assign trig_seen    = bus.bus_rdata[0];
    assign unused_rdata = ^bus.bus_rdata[7:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            p_q           <= 32'd0;
            stop_pend     <= 1'b0;
            bus.bus_addr  <= 16'd0;
            bus.bus_we    <= 1'b0;
            bus.bus_wdata <= 8'd0;
            busy          <= 1'b0;
            tick          <= 1'b0;
            tick_count    <= 16'd0;
        end else begin
            tick <= 1'b0;
            // A stop raised anywhere outside IDLE waits here until POLL.
            if (stop) begin
                stop_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    stop_pend <= 1'b0;
                    if (start) begin
                        p_q           <= p_new;
                        state         <= S_WR3;
                        busy          <= 1'b1;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= A_TMR_3;
                        bus.bus_wdata <= p_new[31:24];
                    end
                end
                S_WR3: begin
                    state         <= S_WR2;
                    bus.bus_addr  <= A_TMR_2;
                    bus.bus_wdata <= p_q[23:16];
                end
                S_WR2: begin
                    state         <= S_WR1;
                    bus.bus_addr  <= A_TMR_1;
                    bus.bus_wdata <= p_q[15:8];
                end
                S_WR1: begin
                    state         <= S_WR0;
                    bus.bus_addr  <= A_TMR_0;
                    bus.bus_wdata <= p_q[7:0];
                end
                S_WR0: begin
                    state         <= S_CLR;
                    bus.bus_addr  <= A_TMR_RST;
                    bus.bus_wdata <= 8'd0;
                    tick_count    <= 16'd0;
                end
                S_CLR: begin
                    state      <= S_POLL;
                    bus.bus_we <= 1'b0;
                end
                S_POLL: begin
                    if (stop_pend) begin
                        state         <= S_IDLE;
                        stop_pend     <= 1'b0;
                        busy          <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_addr  <= 16'd0;
                        bus.bus_wdata <= 8'd0;
                    end else if (trig_seen) begin
                        state      <= S_ACK;
                        bus.bus_we <= 1'b1;
                        tick       <= 1'b1;
                        tick_count <= tick_count + 16'd1;
                    end
                end
                S_ACK: begin
                    state      <= S_POLL;
                    bus.bus_we <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TIMER_POLLER_WDOG_EN
    logic [32:0] poll_cnt;
    logic [32:0] wdog_limit;

    assign wdog_limit = {1'b0, p_q} + 33'(WDOG_MARGIN);

    // Counts POLL cycles without a trigger; reset on entry to CLR and ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= 33'd0;
            wdog_err <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                wdog_err <= 1'b0;
            end
            if (state == S_WR0) begin
                poll_cnt <= 33'd0;
            end else if (state == S_POLL && !stop_pend) begin
                if (trig_seen) begin
                    poll_cnt <= 33'd0;
                end else begin
                    poll_cnt <= poll_cnt + 33'd1;
                    if (poll_cnt + 33'd1 >= wdog_limit) begin
                        wdog_err <= 1'b1;
                    end
                end
            end
        end
    end
`else
    logic [31:0] unused_wdog_margin;
    assign unused_wdog_margin = WDOG_MARGIN;
    assign wdog_err           = 1'b0;
`endif

endmodule

// File: tb/tb_timer_poller.sv
module tb_timer_poller;

    localparam logic [15:0] A_T0  = 16'h0010;
    localparam logic [15:0] A_T1  = 16'h0011;
    localparam logic [15:0] A_T2  = 16'h0012;
    localparam logic [15:0] A_T3  = 16'h0013;
    localparam logic [15:0] A_RST = 16'h0014;
    localparam logic [31:0] DEF_P = 32'h004C4B40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period = 32'd0;
    logic        busy, tick, wdog_err;
    logic [15:0] tick_count;

    int errors = 0;
    int checks = 0;

    timer_poller_if bif();

    timer_poller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .period     (period),
        .bus        (bif),
        .busy       (busy),
        .tick       (tick),
        .tick_count (tick_count),
        .wdog_err   (wdog_err)
    );

    always #5 clk = ~clk;

    // Compliant timer: byte-programmed period, match at count==P then count<=0,
    // triggered flag held until a write to TMR_RST.
    logic [31:0] tmr_period = 32'd0;
    logic [31:0] tmr_cnt = 32'd0;
    logic        tmr_trig = 1'b0;
    logic        tmr_hold = 1'b0;

    assign bif.bus_rdata = {7'd0, tmr_trig};

    always @(posedge clk) begin
        if (bif.bus_we) begin
            case (bif.bus_addr)
                A_T0: tmr_period[7:0]   <= bif.bus_wdata;
                A_T1: tmr_period[15:8]  <= bif.bus_wdata;
                A_T2: tmr_period[23:16] <= bif.bus_wdata;
                A_T3: tmr_period[31:24] <= bif.bus_wdata;
                default: ;
            endcase
        end
        if (tmr_hold || (bif.bus_we && bif.bus_addr == A_RST)) begin
            tmr_cnt  <= 32'd0;
            tmr_trig <= 1'b0;
        end else if (tmr_cnt == tmr_period) begin
            tmr_cnt  <= 32'd0;
            tmr_trig <= 1'b1;
        end else begin
            tmr_cnt <= tmr_cnt + 32'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offset (edges after the accepted start) at which the poller is back in
    // IDLE when the stop pulse is sampled on edge j, for tick interval L.
    function automatic int idle_off_for(input int j, input int l);
        if (j < 5) return 6;
        else if ((j - 4) % l == 0) return j + 2;
        else return j + 1;
    endfunction

    // Expected outputs from the schedule: 4 period writes, CLR at offset 4,
    // then an ACK every P+3 cycles counted from the CLR cycle.
    task automatic check_cycle(input int off, input logic [31:0] p, input int idle_at);
        int l;
        int rel;
        logic ack;
        logic [15:0] wa;
        l = int'(p) + 3;
        if (off >= idle_at) begin
            chk($sformatf("off%0d_idle_busy", off), busy, 0);
            chk($sformatf("off%0d_idle_we", off), bif.bus_we, 0);
            chk($sformatf("off%0d_idle_addr", off), bif.bus_addr, 0);
            chk($sformatf("off%0d_idle_wdata", off), bif.bus_wdata, 0);
            chk($sformatf("off%0d_idle_tick", off), tick, 0);
            chk($sformatf("off%0d_idle_count", off), tick_count, ((idle_at - 5) / l) % 65536);
        end else if (off < 4) begin
            case (off)
                0: wa = A_T3;
                1: wa = A_T2;
                2: wa = A_T1;
                default: wa = A_T0;
            endcase
            chk($sformatf("off%0d_wr_busy", off), busy, 1);
            chk($sformatf("off%0d_wr_we", off), bif.bus_we, 1);
            chk($sformatf("off%0d_wr_addr", off), bif.bus_addr, wa);
            chk($sformatf("off%0d_wr_data", off), bif.bus_wdata, (p >> (8 * (3 - off))) & 32'hFF);
            chk($sformatf("off%0d_wr_tick", off), tick, 0);
        end else if (off == 4) begin
            chk("clr_busy", busy, 1);
            chk("clr_we", bif.bus_we, 1);
            chk("clr_addr", bif.bus_addr, A_RST);
            chk("clr_tick", tick, 0);
            chk("clr_count", tick_count, 0);
        end else begin
            rel = off - 4;
            ack = (rel % l == 0);
            chk($sformatf("off%0d_run_busy", off), busy, 1);
            chk($sformatf("off%0d_run_we", off), bif.bus_we, ack);
            chk($sformatf("off%0d_run_addr", off), bif.bus_addr, A_RST);
            chk($sformatf("off%0d_run_tick", off), tick, ack);
            chk($sformatf("off%0d_run_count", off), tick_count, (rel / l) % 65536);
        end
        chk($sformatf("off%0d_wdog", off), wdog_err, 0);
    endtask

    // One start..stop session. stop is sampled on edge stop_j; a busy start is
    // injected after offset inject_off (negative disables it).
    task automatic run_seq(input logic [31:0] p_in, input int stop_j, input int inject_off);
        logic [31:0] p;
        int idle_at;
        p = (p_in == 32'd0) ? DEF_P : p_in;
        idle_at = idle_off_for(stop_j, int'(p) + 3);
        period = p_in;
        start = 1'b1;
        for (int off = 0; off <= idle_at + 2; off++) begin
            step();
            start = 1'b0;
            stop = 1'b0;
            if (off == 0) period = $urandom();
            check_cycle(off, p, idle_at);
            if (off == stop_j - 1) stop = 1'b1;
            if (off == inject_off) begin
                start = 1'b1;
                period = $urandom_range(1, 50);
            end
        end
        start = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        int p_r, j_r, inj_r;

        #1 rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_we", bif.bus_we, 0);
        chk("rst_addr", bif.bus_addr, 0);
        chk("rst_wdata", bif.bus_wdata, 0);
        chk("rst_tick", tick, 0);
        chk("rst_count", tick_count, 0);
        chk("rst_wdog", wdog_err, 0);
        step();
        rst = 1'b0;
        step();

        // Period 10: three ticks 13 cycles apart, stop afterwards.
        run_seq(32'd10, 45, -1);
        // Stop during WR1 with a start injected while busy.
        run_seq(32'd10, 3, 1);
        // Default period programming.
        run_seq(32'd0, 3, -1);

        repeat (6) begin
            p_r = $urandom_range(1, 12);
            j_r = $urandom_range(5, 5 + 3 * (p_r + 3));
            inj_r = $urandom_range(0, j_r - 1);
            run_seq(p_r, j_r, inj_r);
        end

        // Reset in the middle of polling.
        period = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("midrst_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_we", bif.bus_we, 0);
        chk("midrst_addr", bif.bus_addr, 0);
        chk("midrst_wdata", bif.bus_wdata, 0);
        chk("midrst_tick", tick, 0);
        chk("midrst_count", tick_count, 0);
        chk("midrst_wdog", wdog_err, 0);
        step();
        chk("midrst_hold_we", bif.bus_we, 0);
        rst = 1'b0;
        step();
        chk("postrst_busy", busy, 0);
        chk("postrst_we", bif.bus_we, 0);

`ifdef TIMER_POLLER_WDOG_EN
        tmr_hold = 1'b1;
        period = 32'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int off = 1; off <= 25; off++) begin
            step();
            chk($sformatf("wd_tick_off%0d", off), tick, 0);
            if (off >= 5) chk($sformatf("wd_err_off%0d", off), wdog_err, (off >= 23) ? 1 : 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("wd_stopped_busy", busy, 0);
        chk("wd_sticky", wdog_err, 1);
        period = 32'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("wd_restart_clear", wdog_err, 0);
        chk("wd_restart_busy", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (5) step();
        chk("wd_final_idle", busy, 0);
        tmr_hold = 1'b0;
        step();
`endif

        run_seq(32'd4, 20, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
